// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a single-entry IF/ID register,
// one skid/hold register for words that complete while decode is stalled,
// and branch redirect handling that drains an in-flight request.
// Optional build macro FETCH_STALL_CNT_EN adds a saturating 16-bit
// counter of stalled cycles holding a live instruction (o_stallCnt).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | one cycle after reset release, no request issued
// S_FETCH | request outstanding at r_pc, completions flow into IF/ID
// S_PEND  | word captured in hold register, waiting for decode to drain
// S_DROP  | old request still in flight after redirect, data discarded

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rstN,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirectPc,
    output logic        o_imemReq,
    output logic [31:0] o_imemAddr,
    input  logic        i_imemValid,
    input  logic [31:0] i_imemRdata,
    output logic        o_instrValid,
    output logic [31:0] o_instr,
    output logic [5:0]  o_opcode,
    output logic [31:0] o_pcPlus4
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0] o_stallCnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_PEND  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    // Word-aligned reset address so o_imemAddr[1:0] is always 00.
    localparam logic [31:0] RESET_PC_AL = RESET_PC & 32'hFFFF_FFFC;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_tgtPc;
    logic        r_imemReq;
    logic        r_instrValid;
    logic [31:0] r_instr;
    logic [31:0] r_pcPlus4;
    logic        r_holdValid;
    logic [31:0] r_holdInstr;
    logic [31:0] r_holdPcPlus4;

    logic        w_done;
    logic        w_slotFree;
    logic [31:0] w_redirPc;
    logic [31:0] w_pcNext;

    assign w_done     = r_imemReq & i_imemValid;
    assign w_slotFree = ~r_instrValid | ~i_stall;
    assign w_redirPc  = i_redirectPc & 32'hFFFF_FFFC;
    assign w_pcNext   = r_pc + 32'd4;

    assign o_imemReq    = r_imemReq;
    assign o_imemAddr   = r_pc;
    assign o_instrValid = r_instrValid;
    assign o_instr      = r_instr;
    assign o_opcode     = r_instr[31:26];
    assign o_pcPlus4    = r_pcPlus4;

    // Fetch FSM with registered request, IF/ID and hold registers.
    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC_AL;
            r_tgtPc       <= RESET_PC_AL;
            r_imemReq     <= 1'b0;
            r_instrValid  <= 1'b0;
            r_instr       <= 32'h0;
            r_pcPlus4     <= 32'h0;
            r_holdValid   <= 1'b0;
            r_holdInstr   <= 32'h0;
            r_holdPcPlus4 <= 32'h0;
        end else begin
            // Decode consumes the current word whenever it is not stalled.
            if (!i_stall) begin
                r_instrValid <= 1'b0;
            end

            if (i_redirect) begin
                r_instrValid <= 1'b0;
                r_holdValid  <= 1'b0;
                case (r_state)
                    S_FETCH, S_DROP: begin
                        if (w_done) begin
                            // In-flight request ends now; start at target.
                            r_pc      <= w_redirPc;
                            r_state   <= S_FETCH;
                            r_imemReq <= 1'b1;
                        end else begin
                            // Address must stay stable until the old
                            // request completes, so park the target.
                            r_tgtPc <= w_redirPc;
                            r_state <= S_DROP;
                        end
                    end
                    default: begin
                        r_pc      <= w_redirPc;
                        r_state   <= S_FETCH;
                        r_imemReq <= 1'b1;
                    end
                endcase
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state   <= S_FETCH;
                        r_imemReq <= 1'b1;
                    end
                    S_FETCH: begin
                        if (w_done) begin
                            r_pc <= w_pcNext;
                            if (w_slotFree) begin
                                r_instr      <= i_imemRdata;
                                r_pcPlus4    <= w_pcNext;
                                r_instrValid <= 1'b1;
                            end else begin
                                r_holdInstr   <= i_imemRdata;
                                r_holdPcPlus4 <= w_pcNext;
                                r_holdValid   <= 1'b1;
                                r_state       <= S_PEND;
                                r_imemReq     <= 1'b0;
                            end
                        end
                    end
                    S_PEND: begin
                        if (!i_stall) begin
                            if (r_holdValid) begin
                                r_instr      <= r_holdInstr;
                                r_pcPlus4    <= r_holdPcPlus4;
                                r_instrValid <= 1'b1;
                            end
                            r_holdValid <= 1'b0;
                            r_state     <= S_FETCH;
                            r_imemReq   <= 1'b1;
                        end
                    end
                    S_DROP: begin
                        if (w_done) begin
                            r_pc    <= r_tgtPc;
                            r_state <= S_FETCH;
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_imemReq <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] r_stallCnt;

    assign o_stallCnt = r_stallCnt;

    // Saturating count of cycles a live instruction is held by a stall.
    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            r_stallCnt <= 16'h0;
        end else if (r_instrValid && i_stall && (r_stallCnt != 16'hFFFF)) begin
            r_stallCnt <= r_stallCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming fetch, stall/hold,
// redirect through DROP, same-cycle redirect, PC wrap, reset mid-request.
`timescale 1ns/1ps

module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc_plus4;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_total = 0;
    int n_pass  = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk        (clk),
        .i_rstN       (rst_n),
        .i_stall      (stall),
        .i_redirect   (redirect),
        .i_redirectPc (redirect_pc),
        .o_imemReq    (imem_req),
        .o_imemAddr   (imem_addr),
        .i_imemValid  (imem_valid),
        .i_imemRdata  (imem_rdata),
        .o_instrValid (instr_valid),
        .o_instr      (instr),
        .o_opcode     (opcode),
        .o_pcPlus4    (pc_plus4)
`ifdef FETCH_STALL_CNT_EN
        ,
        .o_stallCnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_valid  = 1'b0;
        imem_rdata  = 32'h0;

        // Reset values, before any clock edge
        #1;
        chk("rst_req",    {31'b0, imem_req},    32'h0);
        chk("rst_valid",  {31'b0, instr_valid}, 32'h0);
        chk("rst_instr",  instr,                32'h0);
        chk("rst_pc4",    pc_plus4,             32'h0);
        chk("rst_addr",   imem_addr,            32'h0);
`ifdef FETCH_STALL_CNT_EN
        chk("rst_scnt",   {16'b0, stall_cnt},   32'h0);
`endif

        // Release reset; memory answers every cycle
        #11;
        rst_n      = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 32'h2000_0001;
        tick();  // IDLE -> FETCH
        chk("idle_req",   {31'b0, imem_req},    32'h1);
        chk("idle_addr",  imem_addr,            32'h0);
        chk("idle_valid", {31'b0, instr_valid}, 32'h0);

        tick();  // addr 0 completes
        chk("w0_valid",   {31'b0, instr_valid}, 32'h1);
        chk("w0_opcode",  {26'b0, opcode},      32'h0000_0008);
        chk("w0_pc4",     pc_plus4,             32'h4);
        chk("w0_addr",    imem_addr,            32'h4);
        imem_rdata = 32'h8C00_0002;

        tick();  // addr 4 completes back-to-back
        chk("w1_valid",   {31'b0, instr_valid}, 32'h1);
        chk("w1_opcode",  {26'b0, opcode},      32'h0000_0023);
        chk("w1_pc4",     pc_plus4,             32'h8);
        chk("w1_addr",    imem_addr,            32'h8);

        // Stall with slot full while addr 8 completes -> PEND
        stall      = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        chk("pend_req",   {31'b0, imem_req},    32'h0);
        chk("pend_instr", instr,                32'h8C00_0002);
        chk("pend_valid", {31'b0, instr_valid}, 32'h1);
        imem_valid = 1'b1;  // ignored: no request outstanding
        imem_rdata = 32'hBEEF_0000;
        tick();
        chk("pend2_req",   {31'b0, imem_req},   32'h0);
        chk("pend2_instr", instr,               32'h8C00_0002);
        tick();
        chk("pend3_instr", instr,               32'h8C00_0002);
        chk("pend3_pc4",   pc_plus4,            32'h8);
`ifdef FETCH_STALL_CNT_EN
        chk("scnt_3",      {16'b0, stall_cnt},  32'h3);
`endif
        stall      = 1'b0;
        imem_valid = 1'b0;
        tick();  // hold word moves into IF/ID, fetch at 12 issues
        chk("drain_instr", instr,               32'h1234_5678);
        chk("drain_pc4",   pc_plus4,            32'hC);
        chk("drain_valid", {31'b0, instr_valid}, 32'h1);
        chk("drain_req",   {31'b0, imem_req},   32'h1);
        chk("drain_addr",  imem_addr,           32'hC);

        tick();  // no completion, not stalled -> bubble
        chk("bub_valid",  {31'b0, instr_valid}, 32'h0);
        chk("bub_addr",   imem_addr,            32'hC);
        imem_valid = 1'b1;
        imem_rdata = 32'hAAAA_0003;
        tick();
        chk("w3_instr",   instr,                32'hAAAA_0003);
        chk("w3_addr",    imem_addr,            32'h10);

        // Redirect while 0x10 outstanding -> DROP
        imem_valid  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0043;
        tick();
        chk("drop_addr",  imem_addr,            32'h10);
        chk("drop_req",   {31'b0, imem_req},    32'h1);
        chk("drop_valid", {31'b0, instr_valid}, 32'h0);
        redirect = 1'b0;
        tick();
        chk("drop2_addr", imem_addr,            32'h10);
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_0000;
        tick();  // stale 0x10 data discarded
        chk("redir_addr",  imem_addr,           32'h40);
        chk("redir_valid", {31'b0, instr_valid}, 32'h0);
        imem_valid = 1'b0;
        tick();
        chk("redir2_valid", {31'b0, instr_valid}, 32'h0);
        imem_valid = 1'b1;
        imem_rdata = 32'h0C00_0040;
        tick();
        chk("t40_instr",  instr,                32'h0C00_0040);
        chk("t40_pc4",    pc_plus4,             32'h44);
        chk("t40_valid",  {31'b0, instr_valid}, 32'h1);

        // Redirect with same-cycle completion; target low bits masked
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        imem_rdata  = 32'h5555_5555;
        tick();
        chk("rc_addr",    imem_addr,            32'hFFFF_FFFC);
        chk("rc_valid",   {31'b0, instr_valid}, 32'h0);
        chk("rc_req",     {31'b0, imem_req},    32'h1);
        redirect   = 1'b0;
        imem_rdata = 32'h1111_1111;
        tick();  // PC wraps
        chk("wrap_addr",  imem_addr,            32'h0);
        chk("wrap_pc4",   pc_plus4,             32'h0);
        chk("wrap_instr", instr,                32'h1111_1111);

        // Reset mid-request at addr 4
        imem_rdata = 32'h3333_3333;
        tick();
        chk("pre_addr",   imem_addr,            32'h4);
        imem_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_req",   {31'b0, imem_req},    32'h0);
        chk("arst_addr",  imem_addr,            32'h0);
        chk("arst_valid", {31'b0, instr_valid}, 32'h0);
        chk("arst_instr", instr,                32'h0);
        #2;
        rst_n      = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 32'h0BAD_0BAD;
        tick();  // IDLE ignores stale valid
        chk("post_valid", {31'b0, instr_valid}, 32'h0);
        chk("post_addr",  imem_addr,            32'h0);
        chk("post_req",   {31'b0, imem_req},    32'h1);
        imem_valid = 1'b0;
        tick();
        chk("post2_valid", {31'b0, instr_valid}, 32'h0);
        imem_valid = 1'b1;
        imem_rdata = 32'h2222_3333;
        tick();
        chk("post_instr", instr,                32'h2222_3333);
        chk("post_pc4",   pc_plus4,             32'h4);

`ifdef FETCH_STALL_CNT_EN
        // Long stall with a live instruction saturates the counter
        imem_valid = 1'b0;
        stall      = 1'b1;
        for (int i = 0; i < 70000; i++) tick();
        chk("scnt_sat",   {16'b0, stall_cnt},   32'h0000_FFFF);
        chk("scnt_valid", {31'b0, instr_valid}, 32'h1);
        stall = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
